fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage: owns the PC and issues single-outstanding requests to instruction memory.
//   Holds each returned word for the decode controller, presented as valid/ready with opcode/funct3/funct7 split out.
//   Accepts branch/jump redirects from execute and discards stale in-flight responses.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset; bits [1:0] must be 0
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   imem_req       out  1   registered one-cycle request pulse
//   imem_addr      out  32  word-aligned fetch address, valid while imem_req=1
//   imem_rvalid    in   1   response strobe; exactly one per request, >=1 cycle after request sampled
//   imem_rdata     in   32  instruction word, valid with imem_rvalid
//   redirect_valid in   1   taken branch/JAL/JALR from execute, single cycle
//   redirect_pc    in   32  target PC; bits [1:0] ignored (forced to 0)
//   inst_valid     out  1   inst/inst_pc hold a live instruction
//   inst_ready     in   1   decode accepts instruction this cycle
//   inst           out  32  held instruction word (32'h0 when not valid)
//   inst_pc        out  32  PC of held instruction
//   opcode         out  7   inst[6:0]
//   funct3         out  3   inst[14:12]
//   funct7         out  7   inst[31:25]
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, inst_valid=0,
//     inst=32'h0 (opcode 0 -> decoder no-op), inst_pc=0. Reset mid-request: response is abandoned; memory must also reset.
//   "Launch": imem_req<=1, imem_addr<=target, state<=WAIT; imem_req auto-clears next cycle.
//   States:
//   - IDLE:  first edge after reset release -> launch pc.
//   - WAIT:  on imem_rvalid: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, -> HOLD.
//   - HOLD:  inst stable while inst_valid=1 & inst_ready=0. On inst_ready=1: inst_valid<=0, inst<=0,
//            launch pc (already pc+4) same edge.
//   - DRAIN: pending response is stale; on imem_rvalid data dropped, launch pc.
//   Redirect (priority over all of the above, same edge):
//   - IDLE/HOLD: pc<=redirect_pc, inst_valid<=0, inst<=0, launch redirect_pc (HOLD discarded even if inst_ready=1).
//   - WAIT with imem_rvalid=1: drop data, pc<=redirect_pc, launch redirect_pc.
//   - WAIT with imem_rvalid=0: pc<=redirect_pc, -> DRAIN, no request.
//   - DRAIN: pc<=redirect_pc (latest wins); with imem_rvalid=1 launch redirect_pc.
//   Never more than one outstanding request; imem_req never asserted in WAIT/DRAIN.
//   Latency: launch edge -> imem_req high 1 cycle -> inst_valid high >=2 edges later; best case 1 instr / 3 cycles.
//   PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. pc[1:0] always 0.
//   opcode/funct3/funct7 purely combinational slices of inst; all other outputs registered.
// TESTING
//   1 Reset RESET_PC=0x100, rvalid 1 cycle after req, inst_ready=1 -> imem_addr 0x100,0x104,0x108; inst_pc matches; req every 3rd cycle.
//   2 Backpressure: inst_ready=0 for 5 cycles in HOLD, rdata=0x00500093 -> inst/opcode=0x13/funct3=0 stable, no new imem_req; releases on ready.
//   3 Redirect in WAIT, rvalid 3 cycles later, redirect_pc=0x200 -> stale word never reaches inst_valid; next req addr 0x200.
//   4 Redirect same cycle as rvalid (0x40 -> 0x80) -> data dropped, imem_req next cycle addr 0x80, no DRAIN.
//   5 Redirect in HOLD with inst_ready=1 -> held instr dropped; redirect_pc=0x303 -> imem_addr 0x300.
//   6 Wrap: redirect to 0xFFFFFFFC, fetch -> next imem_addr 0x0; async reset mid-WAIT -> outputs reset immediately, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory request/response, execute redirect
// and the decoded-instruction handoff towards decode.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, funct3, funct7,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, funct3, funct7,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one request outstanding
// to instruction memory, holds the returned word for decode and discards
// responses made stale by a redirect from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] rpc;
  logic        req_n;
  logic [31:0] addr_n;
  logic        valid_n;
  logic [31:0] inst_n;
  logic [31:0] ipc_n;
  logic        do_launch;
  logic [31:0] tgt;

  assign rpc = bus.redirect_pc & 32'hFFFF_FFFC;

  // Decode fields are plain slices of the held word (all zero when empty).
  assign bus.opcode = bus.inst[6:0];
  assign bus.funct3 = bus.inst[14:12];
  assign bus.funct7 = bus.inst[31:25];

  // Next-state logic; redirect takes priority over every other event.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_n     = 1'b0;
    addr_n    = bus.imem_addr;
    valid_n   = bus.inst_valid;
    inst_n    = bus.inst;
    ipc_n     = bus.inst_pc;
    do_launch = 1'b0;
    tgt       = pc;
    case (state)
      IDLE: begin
        do_launch = 1'b1;
        if (bus.redirect_valid) begin
          pc_n = rpc;
          tgt  = rpc;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_n = rpc;
          if (bus.imem_rvalid) begin
            do_launch = 1'b1;
            tgt       = rpc;
          end else begin
            state_n = DRAIN;
          end
        end else if (bus.imem_rvalid) begin
          inst_n  = bus.imem_rdata;
          ipc_n   = pc;
          valid_n = 1'b1;
          pc_n    = pc + 32'd4;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_n      = rpc;
          valid_n   = 1'b0;
          inst_n    = '0;
          do_launch = 1'b1;
          tgt       = rpc;
        end else if (bus.inst_ready) begin
          valid_n   = 1'b0;
          inst_n    = '0;
          do_launch = 1'b1;
        end
      end
      default: begin // DRAIN: latest redirect target wins
        if (bus.redirect_valid) begin
          pc_n = rpc;
          tgt  = rpc;
        end
        do_launch = bus.imem_rvalid;
      end
    endcase
    if (do_launch) begin
      req_n   = 1'b1;
      addr_n  = tgt;
      state_n = WAIT;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC & 32'hFFFF_FFFC;
      bus.imem_req   <= 1'b0;
      bus.imem_addr  <= '0;
      bus.inst_valid <= 1'b0;
      bus.inst       <= '0;
      bus.inst_pc    <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      bus.imem_req   <= req_n;
      bus.imem_addr  <= addr_n;
      bus.inst_valid <= valid_n;
      bus.inst       <= inst_n;
      bus.inst_pc    <= ipc_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirects in
// WAIT/HOLD, PC wrap and asynchronous reset mid-request.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'b0, bus.imem_req},   32'h0);
    check({tag, "_addr"},  bus.imem_addr,           32'h0);
    check({tag, "_valid"}, {31'b0, bus.inst_valid}, 32'h0);
    check({tag, "_inst"},  bus.inst,                32'h0);
    check({tag, "_ipc"},   bus.inst_pc,             32'h0);
    check({tag, "_opc"},   {25'b0, bus.opcode},     32'h0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    // Reset values
    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: sequential fetch from 0x100, one instruction every 3 cycles
    for (int i = 0; i < 3; i++) begin
      check("seq_req",   {31'b0, bus.imem_req}, 32'h1);
      check("seq_addr",  bus.imem_addr, 32'h100 + 32'(4 * i));
      tick();
      check("seq_req_lo", {31'b0, bus.imem_req}, 32'h0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hA000_0000 + 32'(i);
      tick();
      bus.imem_rvalid = 1'b0;
      check("seq_valid", {31'b0, bus.inst_valid}, 32'h1);
      check("seq_inst",  bus.inst, 32'hA000_0000 + 32'(i));
      check("seq_ipc",   bus.inst_pc, 32'h100 + 32'(4 * i));
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
      check("seq_drop", {31'b0, bus.inst_valid}, 32'h0);
      check("seq_clr",  bus.inst, 32'h0);
    end

    // 2: backpressure in HOLD, addi x1,x0,5
    check("bp_addr", bus.imem_addr, 32'h10C);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    tick();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, bus.inst_valid}, 32'h1);
      check("bp_inst",  bus.inst, 32'h0050_0093);
      check("bp_opc",   {25'b0, bus.opcode}, 32'h13);
      check("bp_f3",    {29'b0, bus.funct3}, 32'h0);
      check("bp_f7",    {25'b0, bus.funct7}, 32'h0);
      check("bp_noreq", {31'b0, bus.imem_req}, 32'h0);
      tick();
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("bp_rel_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("bp_rel_req",   {31'b0, bus.imem_req}, 32'h1);
    check("bp_rel_addr",  bus.imem_addr, 32'h110);

    // 3: redirect in WAIT, stale response arrives 3 cycles later
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    check("drain_noreq", {31'b0, bus.imem_req}, 32'h0);
    tick();
    tick();
    check("drain_noreq2", {31'b0, bus.imem_req}, 32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    check("drain_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("drain_req",   {31'b0, bus.imem_req}, 32'h1);
    check("drain_addr",  bus.imem_addr, 32'h200);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1111_1111;
    tick();
    bus.imem_rvalid = 1'b0;
    check("post_drain_inst", bus.inst, 32'h1111_1111);
    check("post_drain_ipc",  bus.inst_pc, 32'h200);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("post_drain_addr", bus.imem_addr, 32'h204);

    // 4: redirect coincident with rvalid (to 0x40, then 0x40 -> 0x80)
    tick();
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'h5555_5555;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    check("rv_req40",  {31'b0, bus.imem_req}, 32'h1);
    check("rv_addr40", bus.imem_addr, 32'h40);
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'h6666_6666;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    tick();
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    check("rv_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("rv_req80", {31'b0, bus.imem_req}, 32'h1);
    check("rv_addr80", bus.imem_addr, 32'h80);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h2222_2222;
    tick();
    bus.imem_rvalid = 1'b0;
    check("rv_inst", bus.inst, 32'h2222_2222);
    check("rv_ipc",  bus.inst_pc, 32'h80);

    // 5: redirect in HOLD wins over inst_ready; low bits of target ignored
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h303;
    tick();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    check("hold_rd_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("hold_rd_inst",  bus.inst, 32'h0);
    check("hold_rd_req",   {31'b0, bus.imem_req}, 32'h1);
    check("hold_rd_addr",  bus.imem_addr, 32'h300);

    // 6: PC wrap at 0xFFFFFFFC, then async reset mid-WAIT
    tick();
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'h3333_3333;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h4444_4444;
    tick();
    bus.imem_rvalid = 1'b0;
    check("wrap_ipc",  bus.inst_pc, 32'hFFFF_FFFC);
    check("wrap_inst", bus.inst, 32'h4444_4444);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("wrap_req",  {31'b0, bus.imem_req}, 32'h1);
    check("wrap_addr", bus.imem_addr, 32'h0);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h7777_7777;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_req",  {31'b0, bus.imem_req}, 32'h1);
    check("arst_addr", bus.imem_addr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
